cnn_mac_pipe: RTL and testbench

CNN_MAC_PIPE -- requirements
Module: cnn_mac_pipe

---
 rtl/cnn_mac_pkg.sv | 27 ++
 rtl/cnn_mac_pipe_mul.sv | 95 +++++++++
 rtl/cnn_mac_pipe.sv | 186 ++++++++++++++++++
 tb/tb_cnn_mac_pipe.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_mac_pkg.sv
// -----------------------------------------------------------------------------
// cnn_mac_pkg
// Shared constants for the CNN multiply-accumulate pipeline:
//   - default operand / accumulator widths
//   - legal range of the multiplier pipeline depth
//   - prod_w(): width of the exact signed product of a signed A_W operand and
//     an unsigned B_W operand
// Optional feature macro used by the design: CNN_MAC_SAT_EN (saturating
// accumulator; wrapping accumulator when undefined).
// -----------------------------------------------------------------------------
package cnn_mac_pkg;

    localparam int DEF_A_W         = 14;
    localparam int DEF_B_W         = 6;
    localparam int DEF_NUM_STAGE   = 3;
    localparam int DEF_ACC_W       = 32;

    localparam int NUM_STAGE_MIN   = 1;
    localparam int NUM_STAGE_MAX   = 4;

    // signed(A_W) * unsigned(B_W): the unsigned operand gains a zero sign bit,
    // but the largest magnitude -2^(A_W-1) * (2^B_W - 1) still fits in A_W+B_W.
    function automatic int prod_w(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

endpackage : cnn_mac_pkg

// File: rtl/cnn_mac_pipe_mul.sv
// -----------------------------------------------------------------------------
// cnn_mac_pipe_mul
// Exact signed x unsigned multiplier followed by a NUM_STAGE-deep register
// pipeline. The valid / first / last tags travel in lockstep with the data.
// The product appears on prod NUM_STAGE ce-active cycles after the operand is
// accepted (ce=1 and in_vld=1).
//
// Ports:
//   ap_clk     in   clock, rising edge
//   ap_rst     in   synchronous active-high reset (wins over ce)
//   ce         in   clock enable; 0 freezes every register
//   in_vld     in   operand valid
//   in_first   in   first term of a sum
//   in_last    in   last term of a sum
//   din0       in   [A_W-1:0] signed operand
//   din1       in   [B_W-1:0] unsigned operand
//   prod       out  [A_W+B_W-1:0] signed product (registered)
//   out_vld    out  product valid (registered)
//   out_first  out  first tag aligned with prod
//   out_last   out  last tag aligned with prod
// -----------------------------------------------------------------------------
module cnn_mac_pipe_mul
    import cnn_mac_pkg::*;
#(
    parameter int A_W       = DEF_A_W,
    parameter int B_W       = DEF_B_W,
    parameter int NUM_STAGE = DEF_NUM_STAGE
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   ce,
    input  logic                   in_vld,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic [A_W-1:0]         din0,
    input  logic [B_W-1:0]         din1,
    output logic [A_W+B_W-1:0]     prod,
    output logic                   out_vld,
    output logic                   out_first,
    output logic                   out_last
);

    localparam int PW = prod_w(A_W, B_W);

    if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_stage
        $error("cnn_mac_pipe_mul: NUM_STAGE=%0d outside %0d..%0d",
               NUM_STAGE, NUM_STAGE_MIN, NUM_STAGE_MAX);
    end

    // Both operands widened to the product width before multiplying, so the
    // multiply is performed in PW bits and is exact (no truncation of a
    // representable result). din1 is zero-extended: it is unsigned.
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod_c;

    assign a_ext  = PW'($signed(din0));
    assign b_ext  = PW'({1'b0, din1});
    assign prod_c = a_ext * b_ext;

    logic [PW-1:0]        data_q [NUM_STAGE];
    logic [NUM_STAGE-1:0] vld_q;
    logic [NUM_STAGE-1:0] first_q;
    logic [NUM_STAGE-1:0] last_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                data_q[i] <= '0;
            end
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
        end else if (ce) begin
            // Tags are qualified by in_vld so a stray first/last on an idle
            // cycle can never reach the accumulator.
            data_q[0]  <= prod_c;
            vld_q[0]   <= in_vld;
            first_q[0] <= in_vld & in_first;
            last_q[0]  <= in_vld & in_last;
            for (int i = 1; i < NUM_STAGE; i++) begin
                data_q[i]  <= data_q[i-1];
                vld_q[i]   <= vld_q[i-1];
                first_q[i] <= first_q[i-1];
                last_q[i]  <= last_q[i-1];
            end
        end
    end

    assign prod      = data_q[NUM_STAGE-1];
    assign out_vld   = vld_q[NUM_STAGE-1];
    assign out_first = first_q[NUM_STAGE-1];
    assign out_last  = last_q[NUM_STAGE-1];

endmodule : cnn_mac_pipe_mul

// File: rtl/cnn_mac_pipe.sv
// -----------------------------------------------------------------------------
// cnn_mac_pipe
// Pipelined multiply-accumulate for CNN dot products. Each accepted operand
// pair (ce=1, in_vld=1) is multiplied exactly (signed din0 x unsigned din1);
// products are summed per group delimited by in_first / in_last. The group
// sum is registered to acc_out with a one-cycle acc_vld pulse NUM_STAGE+1
// ce-active cycles after the last term was accepted. Groups may follow each
// other back to back with no bubble.
//
// Optional feature (macro CNN_MAC_SAT_EN):
//   defined   - accumulator saturates to the signed ACC_W range; sat_flag is
//               sticky within a group, cleared by a first term and presented
//               alongside acc_vld.
//   undefined - accumulator wraps modulo 2^ACC_W; sat_flag is tied to 0.
//
// Parameters: ID (tag only), A_W, B_W, NUM_STAGE (1..4), ACC_W (>= A_W+B_W)
//
// Ports:
//   ap_clk    in   clock, rising edge
//   ap_rst    in   synchronous active-high reset (wins over ce)
//   ce        in   clock enable; 0 freezes all state
//   in_vld    in   operand valid
//   in_first  in   first term of a sum
//   in_last   in   last term of a sum
//   din0      in   [A_W-1:0] signed operand
//   din1      in   [B_W-1:0] unsigned operand
//   prod      out  [A_W+B_W-1:0] signed product (registered)
//   prod_vld  out  product valid (registered)
//   acc_out   out  [ACC_W-1:0] signed group sum, held between pulses
//   acc_vld   out  one-cycle group sum valid
//   sat_flag  out  saturation occurred in the reported group
// -----------------------------------------------------------------------------
module cnn_mac_pipe
    import cnn_mac_pkg::*;
#(
    parameter logic [31:0] ID        = 32'd1,
    parameter int          A_W       = DEF_A_W,
    parameter int          B_W       = DEF_B_W,
    parameter int          NUM_STAGE = DEF_NUM_STAGE,
    parameter int          ACC_W     = DEF_ACC_W
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   ce,
    input  logic                   in_vld,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic [A_W-1:0]         din0,
    input  logic [B_W-1:0]         din1,
    output logic [A_W+B_W-1:0]     prod,
    output logic                   prod_vld,
    output logic [ACC_W-1:0]       acc_out,
    output logic                   acc_vld,
    output logic                   sat_flag
);

    localparam int PW = prod_w(A_W, B_W);

    if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_stage
        $error("cnn_mac_pipe ID=%0d: NUM_STAGE=%0d outside %0d..%0d",
               ID, NUM_STAGE, NUM_STAGE_MIN, NUM_STAGE_MAX);
    end
    if (ACC_W < PW) begin : g_bad_acc
        $error("cnn_mac_pipe ID=%0d: ACC_W=%0d narrower than product width %0d",
               ID, ACC_W, PW);
    end
    if (A_W < 2 || B_W < 1) begin : g_bad_operand
        $error("cnn_mac_pipe ID=%0d: A_W=%0d / B_W=%0d too small", ID, A_W, B_W);
    end

    // -------------------------------------------------------------------------
    // Multiplier pipeline
    // -------------------------------------------------------------------------
    logic [PW-1:0] mul_prod;
    logic          mul_vld;
    logic          mul_first;
    logic          mul_last;

    cnn_mac_pipe_mul #(
        .A_W       (A_W),
        .B_W       (B_W),
        .NUM_STAGE (NUM_STAGE)
    ) u_mul (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .ce        (ce),
        .in_vld    (in_vld),
        .in_first  (in_first),
        .in_last   (in_last),
        .din0      (din0),
        .din1      (din1),
        .prod      (mul_prod),
        .out_vld   (mul_vld),
        .out_first (mul_first),
        .out_last  (mul_last)
    );

    assign prod     = mul_prod;
    assign prod_vld = mul_vld;

    // -------------------------------------------------------------------------
    // Accumulator
    // -------------------------------------------------------------------------
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_q,     acc_d;
    logic        [ACC_W-1:0] acc_out_q, acc_out_d;
    logic                    acc_vld_q, acc_vld_d;

    assign prod_ext = ACC_W'($signed(mul_prod));

`ifdef CNN_MAC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] ACC_MAX = ~ACC_MIN;

    // One guard bit: overflow is visible as the two top bits disagreeing.
    logic signed [ACC_W:0] sum_wide;
    logic                  sum_ovf;
    logic                  clamp;
    logic                  sat_grp_q,  sat_grp_d;
    logic                  sat_flag_q, sat_flag_d;

    assign sum_wide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_ext);
    assign sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    assign acc_sum  = !sum_ovf ? sum_wide[ACC_W-1:0]
                    : (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX);
    // A first term loads, it never adds, so it can never clamp.
    assign clamp    = mul_vld & ~mul_first & sum_ovf;

    always_comb begin
        sat_grp_d  = sat_grp_q;
        sat_flag_d = sat_flag_q;
        if (mul_vld) begin
            sat_grp_d = (mul_first ? 1'b0 : sat_grp_q) | clamp;
            if (mul_last) begin
                sat_flag_d = sat_grp_d;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            sat_grp_q  <= 1'b0;
            sat_flag_q <= 1'b0;
        end else if (ce) begin
            sat_grp_q  <= sat_grp_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    assign sat_flag = sat_flag_q;
`else
    assign acc_sum  = acc_q + prod_ext;
    assign sat_flag = 1'b0;
`endif

    always_comb begin
        acc_d     = acc_q;
        acc_out_d = acc_out_q;
        acc_vld_d = 1'b0;
        if (mul_vld) begin
            // A term with no preceding first simply adds to whatever is held.
            acc_d = mul_first ? prod_ext : acc_sum;
            if (mul_last) begin
                acc_out_d = acc_d;
                acc_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc_q     <= '0;
            acc_out_q <= '0;
            acc_vld_q <= 1'b0;
        end else if (ce) begin
            acc_q     <= acc_d;
            acc_out_q <= acc_out_d;
            acc_vld_q <= acc_vld_d;
        end
    end

    assign acc_out = acc_out_q;
    assign acc_vld = acc_vld_q;

endmodule : cnn_mac_pipe

// File: tb/tb_cnn_mac_pipe.sv
// -----------------------------------------------------------------------------
// tb_cnn_mac_pipe
// Directed vectors with hand-computed expected values for cnn_mac_pipe.
// Two instances share the stimulus: dut (default widths) and dut20
// (ACC_W=20, used for the accumulator overflow case). Expected results for
// the overflow case follow CNN_MAC_SAT_EN.
// -----------------------------------------------------------------------------
module tb_cnn_mac_pipe;

    // ---------------------------------------------------------------- clock/reset
    logic        ap_clk   = 1'b0;
    logic        ap_rst   = 1'b1;
    logic        ce       = 1'b0;
    logic        in_vld   = 1'b0;
    logic        in_first = 1'b0;
    logic        in_last  = 1'b0;
    logic [13:0] din0     = '0;
    logic [5:0]  din1     = '0;

    logic [19:0] prod,     prod20;
    logic        prod_vld, prod_vld20;
    logic [31:0] acc_out;
    logic [19:0] acc_out20;
    logic        acc_vld,  acc_vld20;
    logic        sat_flag, sat_flag20;

    int          n_vec  = 0;
    int          n_miss = 0;
    int unsigned cyc    = 0;

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    cnn_mac_pipe dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ce       (ce),
        .in_vld   (in_vld),
        .in_first (in_first),
        .in_last  (in_last),
        .din0     (din0),
        .din1     (din1),
        .prod     (prod),
        .prod_vld (prod_vld),
        .acc_out  (acc_out),
        .acc_vld  (acc_vld),
        .sat_flag (sat_flag)
    );

    cnn_mac_pipe #(.ID(32'd20), .ACC_W(20)) dut20 (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ce       (ce),
        .in_vld   (in_vld),
        .in_first (in_first),
        .in_last  (in_last),
        .din0     (din0),
        .din1     (din1),
        .prod     (prod20),
        .prod_vld (prod_vld20),
        .acc_out  (acc_out20),
        .acc_vld  (acc_vld20),
        .sat_flag (sat_flag20)
    );

    // ---------------------------------------------------------------- scoreboard
    // Observed acc_vld pulses; each test compares them against its own
    // hand-computed expectations.
    logic [31:0] obs_q[$];
    logic        obs_sat_q[$];
    int unsigned obs_cyc_q[$];
    logic [19:0] obs20_q[$];
    logic        obs20_sat_q[$];

    always @(negedge ap_clk) begin
        if (acc_vld) begin
            obs_q.push_back(acc_out);
            obs_sat_q.push_back(sat_flag);
            obs_cyc_q.push_back(cyc);
        end
        if (acc_vld20) begin
            obs20_q.push_back(acc_out20);
            obs20_sat_q.push_back(sat_flag20);
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic step(input int n);
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_sat_q.delete();
        obs_cyc_q.delete();
        obs20_q.delete();
        obs20_sat_q.delete();
    endtask

    task automatic drive(input int a, input int b, input logic f, input logic l);
        din0     = 14'(a);
        din1     = 6'(b);
        in_vld   = 1'b1;
        in_first = f;
        in_last  = l;
        step(1);
        in_vld   = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        step(1);
        ap_rst = 1'b0;
        clear_obs();
    endtask

    // ---------------------------------------------------------------- tests
    int unsigned s;
    longint      exp20;
    logic        exp20_sat;

    initial begin
        // Reset with ce=0: reset still applies.
        step(2);
        check("rst_prod",     $signed(prod), 0);
        check("rst_prod_vld", prod_vld, 0);
        check("rst_acc_out",  $signed(acc_out), 0);
        check("rst_acc_vld",  acc_vld, 0);
        check("rst_sat_flag", sat_flag, 0);
        ap_rst = 1'b0;
        ce     = 1'b1;
        clear_obs();

        // Single term, min din0 x max din1: latency of prod and acc_vld.
        drive(-8192, 63, 1'b1, 1'b1);
        check("single_pv_c1", prod_vld, 0);
        step(1);
        check("single_pv_c2", prod_vld, 0);
        step(1);
        check("single_pv_c3", prod_vld, 1);
        check("single_prod",  $signed(prod), -516096);
        check("single_av_c3", acc_vld, 0);
        step(1);
        check("single_av_c4", acc_vld, 1);
        check("single_acc",   $signed(acc_out), -516096);
        check("single_pv_c4", prod_vld, 0);
        step(1);
        check("single_av_c5", acc_vld, 0);
        check("single_hold",  $signed(acc_out), -516096);

        // Three-term group.
        do_reset();
        drive(8191, 63, 1'b1, 1'b0);
        s = cyc;
        drive(-1, 1, 1'b0, 1'b0);
        drive(100, 0, 1'b0, 1'b1);
        step(6);
        check("grp3_pulses", obs_q.size(), 1);
        if (obs_q.size() == 1) begin
            check("grp3_acc", $signed(obs_q[0]), 516032);
            check("grp3_cyc", obs_cyc_q[0], s + 5);
        end

        // Same group with ce low for 2 cycles mid-group, in_vld ignored then.
        do_reset();
        drive(8191, 63, 1'b1, 1'b0);
        s = cyc;
        drive(-1, 1, 1'b0, 1'b0);
        ce       = 1'b0;
        din0     = 14'd1000;
        din1     = 6'd5;
        in_vld   = 1'b1;
        in_first = 1'b1;
        in_last  = 1'b1;
        step(2);
        ce       = 1'b1;
        in_vld   = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        drive(100, 0, 1'b0, 1'b1);
        step(8);
        check("ce_pulses", obs_q.size(), 1);
        if (obs_q.size() == 1) begin
            check("ce_acc", $signed(obs_q[0]), 516032);
            check("ce_cyc", obs_cyc_q[0], s + 7);
        end

        // Back-to-back groups.
        do_reset();
        drive(2, 2, 1'b1, 1'b0);
        s = cyc;
        drive(3, 3, 1'b0, 1'b1);
        drive(1, 1, 1'b1, 1'b1);
        step(6);
        check("b2b_pulses", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check("b2b_acc0", $signed(obs_q[0]), 13);
            check("b2b_acc1", $signed(obs_q[1]), 1);
            check("b2b_cyc0", obs_cyc_q[0], s + 4);
            check("b2b_cyc1", obs_cyc_q[1], s + 5);
        end

        // Reset mid-group: acc_out (1 from above) must clear, group discarded.
        clear_obs();
        drive(100, 10, 1'b1, 1'b0);
        drive(7, 7, 1'b0, 1'b0);
        ap_rst = 1'b1;
        step(1);
        ap_rst = 1'b0;
        check("midrst_prod",     $signed(prod), 0);
        check("midrst_prod_vld", prod_vld, 0);
        check("midrst_acc_out",  $signed(acc_out), 0);
        check("midrst_acc_vld",  acc_vld, 0);
        check("midrst_sat",      sat_flag, 0);
        step(6);
        check("midrst_pulses", obs_q.size(), 0);
        drive(5, 3, 1'b1, 1'b1);
        step(5);
        check("post_rst_pulses", obs_q.size(), 1);
        if (obs_q.size() == 1) begin
            check("post_rst_acc", $signed(obs_q[0]), 15);
        end

        // Term without a first after reset adds onto 0.
        do_reset();
        drive(4, 5, 1'b0, 1'b1);
        step(5);
        check("nofirst_pulses", obs_q.size(), 1);
        if (obs_q.size() == 1) begin
            check("nofirst_acc", $signed(obs_q[0]), 20);
        end

        // Accumulator overflow on the ACC_W=20 instance; 32-bit one is exact.
`ifdef CNN_MAC_SAT_EN
        exp20     = 524287;
        exp20_sat = 1'b1;
`else
        exp20     = -16510;
        exp20_sat = 1'b0;
`endif
        do_reset();
        drive(8191, 63, 1'b1, 1'b0);
        drive(8191, 63, 1'b0, 1'b1);
        step(6);
        check("ovf20_pulses", obs20_q.size(), 1);
        if (obs20_q.size() == 1) begin
            check("ovf20_acc", $signed(obs20_q[0]), exp20);
            check("ovf20_sat", obs20_sat_q[0], exp20_sat);
        end
        check("ovf32_pulses", obs_q.size(), 1);
        if (obs_q.size() == 1) begin
            check("ovf32_acc", $signed(obs_q[0]), 1032066);
            check("ovf32_sat", obs_sat_q[0], 0);
        end

        // Next group on the narrow instance starts clean.
        clear_obs();
        drive(5, 3, 1'b1, 1'b1);
        step(5);
        check("clr20_pulses", obs20_q.size(), 1);
        if (obs20_q.size() == 1) begin
            check("clr20_acc", $signed(obs20_q[0]), 15);
            check("clr20_sat", obs20_sat_q[0], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_cnn_mac_pipe
